grid_video_renderer: RTL and testbench
======================================

Name: grid_video_renderer

Overview:
- Downstream consumer of the snake game's flat 30x40 cell bitmap.
- Generates raster timing and scales each grid cell to a CELL_PX x CELL_PX pixel block.
- Produces registered sync, data-enable and 24-bit RGB for the video output path.
- Latches the bitmap once per frame so every displayed frame is tear-free.

Parameters:
GRID_ROWS, 30, bitmap rows
GRID_COLS, 40, bitmap columns
CELL_PX, 8, pixels per cell edge (power of two not required)
PIX_DIV, 8, clk_74a cycles per pixel (>=1)
H_ACTIVE, 320, active pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 32, hsync width
H_BP, 32, horizontal back porch
V_ACTIVE, 240, active lines
V_FP, 3, vertical front porch
V_SYNC, 4, vsync width
V_BP, 13, vertical back porch
FG_RGB, 24'h00FF00, colour of a set cell
BG_RGB, 24'h000000, colour of a clear cell and of active area outside the grid

Ports:
clk_74a  in  1  sole clock
reset_n  in  1  synchronous, active-low reset
grid_in  in  GRID_ROWS*GRID_COLS  cell bitmap; bit index r*GRID_COLS+c = row r, column c (1 = lit)
pix_en  out  1  one-clock pixel strobe, every PIX_DIV clocks
video_hs  out  1  hsync, active high
video_vs  out  1  vsync, active high
video_de  out  1  active-video qualifier
video_rgb  out  24  pixel colour {R,G,B}; 0 when video_de=0
frame_start  out  1  one-clock pulse with output pixel (0,0)

Behaviour:
- Interface: one clock, clk_74a; reset_n is synchronous and active-low.
- Reset (reset_n=0 at a clk_74a edge):
  - All counters and pipeline registers go to 0.
  - Shadow bitmap clears to 0.
  - All outputs go to 0.
  - Reset asserted mid-frame abandons the frame; after release, the raster restarts at h=0, v=0.
- Pixel divider: div_cnt counts 0..PIX_DIV-1. pix_en=1 on the clock where div_cnt==PIX_DIV-1. PIX_DIV=1 gives pix_en=1 every clock.
- Raster counters advance only on pix_en:
  - h_cnt counts 0..H_TOTAL-1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP.
  - When h_cnt wraps, v_cnt advances 0..V_TOTAL-1, wrapping to 0.
- Cell mapping: no divider. Separate counters sub_x/col and sub_y/row derive the cell:
  - sub_x counts 0..CELL_PX-1 within active h. On reaching CELL_PX-1 it wraps and col increments.
  - sub_x and col clear at h_cnt==0.
  - sub_y and row behave the same per active line and clear at v_cnt==0.
- Raw timing per (h_cnt, v_cnt):
  - de = h<H_ACTIVE && v<V_ACTIVE.
  - hs = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vs likewise with the V_* parameters.
- Frame snapshot: shadow <= grid_in on the pix_en clock where h_cnt==0 && v_cnt==V_ACTIVE (first blanking line). grid_in changes at any other time have no effect until the next snapshot.
- Pipeline, advancing on pix_en only:
  - Stage 1 registers the bit index row*GRID_COLS+col, an in_grid flag (row<GRID_ROWS && col<GRID_COLS), and de/hs/vs.
  - Stage 2 registers the outputs:
    - video_rgb = !de ? 0 : (in_grid && shadow[idx]) ? FG_RGB : BG_RGB.
    - video_de, video_hs and video_vs are the stage-1 values.
  - Latency: outputs lag the counters by exactly 2 pixel ticks, and all outputs stay mutually aligned.
  - Outputs hold between pix_en strobes.
- frame_start: 1 for one clock, on the clock the stage-2 registers load pixel (0,0) with de=1.
- Grid smaller than active area (e.g. CELL_PX=8, 40 cols gives 320 px exactly; larger H_ACTIVE pads): out-of-grid active pixels show BG_RGB.

Optional Feature:
- Macro: GRID_LINES_EN.
- Defined:
  - Adds parameter LINE_RGB, default 24'h202020.
  - An active, in-grid pixel with sub_x==0 or sub_y==0 whose cell is clear outputs LINE_RGB.
  - Lit cells are unaffected.
- Undefined: no grid lines; behaviour as above; no LINE_RGB logic is generated.

Test Plan:
- Reset + free-run with defaults:
  - pix_en period is 8 clocks.
  - video_hs high for 32 pix_en per line, starting at h=336.
  - 400 pix_en per line; video_vs high for lines 243..246.
  - 260 lines per frame.
- grid_in bit 0 set, rest clear -> first frame after a snapshot shows FG_RGB for pixels x 0..7, y 0..7 only; all other active pixels show BG_RGB.
- Set bit 29*40+39=1199 -> FG only at x 312..319, y 232..239; video_rgb=0 whenever video_de=0.
- Toggle grid_in mid-active-frame (line 100) -> displayed frame unchanged; the change appears from the next frame.
- Assert reset_n=0 for 3 clocks at line 150, then release:
  - All outputs 0 during reset.
  - First frame_start occurs 2 pixel ticks after the counters restart at (0,0).
- With GRID_LINES_EN, all cells clear -> pixel (8,5) = LINE_RGB, (9,5) = BG_RGB, (9,8) = LINE_RGB.

Source files
------------

// File: rtl/grid_video_renderer.sv
// grid_video_renderer
//
// Purpose: turns the snake game's flat cell bitmap into a raster video
// stream. A pixel divider paces a horizontal/vertical raster. Each grid cell
// is drawn as a CELL_PX x CELL_PX block. Sync, data-enable and RGB leave the
// block registered and mutually aligned.
//
// Ports:
//   clk_74a     in   sole clock
//   reset_n     in   synchronous, active-low reset
//   grid_in     in   GRID_ROWS*GRID_COLS bitmap, bit r*GRID_COLS+c = cell (r,c)
//   pix_en      out  one-clock pixel strobe, once every PIX_DIV clocks
//   video_hs    out  hsync, active high
//   video_vs    out  vsync, active high
//   video_de    out  active-video qualifier
//   video_rgb   out  {R,G,B}; 0 whenever video_de is 0
//   frame_start out  one-clock pulse when pixel (0,0) reaches the outputs
//
// Strobe semantics: there is no handshake. Outputs change only on clocks
// where pix_en is 1 and hold in between. frame_start is the one exception:
// it is high for only the single clock that loads pixel (0,0).
//
// Optional feature: define GRID_LINES_EN to draw clear cells with a
// LINE_RGB border on their first pixel column and first pixel row.
module grid_video_renderer #(
  parameter int          GRID_ROWS = 30,
  parameter int          GRID_COLS = 40,
  parameter int          CELL_PX   = 8,
  parameter int          PIX_DIV   = 8,
  parameter int          H_ACTIVE  = 320,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 32,
  parameter int          H_BP      = 32,
  parameter int          V_ACTIVE  = 240,
  parameter int          V_FP      = 3,
  parameter int          V_SYNC    = 4,
  parameter int          V_BP      = 13,
  parameter logic [23:0] FG_RGB    = 24'h00FF00,
  parameter logic [23:0] BG_RGB    = 24'h000000
`ifdef GRID_LINES_EN
  ,
  parameter logic [23:0] LINE_RGB  = 24'h202020
`endif
) (
  input  logic                           clk_74a,
  input  logic                           reset_n,
  input  logic [GRID_ROWS*GRID_COLS-1:0] grid_in,
  output logic                           pix_en,
  output logic                           video_hs,
  output logic                           video_vs,
  output logic                           video_de,
  output logic [23:0]                    video_rgb,
  output logic                           frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int NBITS   = GRID_ROWS * GRID_COLS;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int SUB_W   = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam int COL_W   = $clog2(H_ACTIVE + 1);
  localparam int ROW_W   = $clog2(V_ACTIVE + 1);
  localparam int IDX_W   = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL_PX - 1);
  localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0]   H_ACT    = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0]   HS_BEG   = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0]   HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]   V_ACT    = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0]   VS_BEG   = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0]   VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [H_W-1:0]   h_cnt_q, h_cnt_d;
  logic [V_W-1:0]   v_cnt_q, v_cnt_d;
  logic [SUB_W-1:0] sub_x_q, sub_x_d, sub_y_q, sub_y_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [NBITS-1:0] shadow_q, shadow_d;

  // Stage 1: cell address and raw timing for the pixel under the counters.
  logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
  logic             s1_in_grid_q, s1_in_grid_d;
  logic             s1_de_q, s1_de_d, s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
  logic             s1_first_q, s1_first_d;
`ifdef GRID_LINES_EN
  logic             s1_line_q, s1_line_d;
`endif

  // Stage 2: the registered outputs.
  logic [23:0] rgb_q, rgb_d;
  logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;

  logic tick, h_wrap, v_wrap;

  always_comb begin
    div_cnt_d    = div_cnt_q;
    h_cnt_d      = h_cnt_q;
    v_cnt_d      = v_cnt_q;
    sub_x_d      = sub_x_q;
    sub_y_d      = sub_y_q;
    col_d        = col_q;
    row_d        = row_q;
    shadow_d     = shadow_q;
    s1_idx_d     = s1_idx_q;
    s1_in_grid_d = s1_in_grid_q;
    s1_de_d      = s1_de_q;
    s1_hs_d      = s1_hs_q;
    s1_vs_d      = s1_vs_q;
    s1_first_d   = s1_first_q;
`ifdef GRID_LINES_EN
    s1_line_d    = s1_line_q;
`endif
    rgb_d        = rgb_q;
    de_d         = de_q;
    hs_d         = hs_q;
    vs_d         = vs_q;
    fs_d         = 1'b0;

    tick   = (div_cnt_q == DIV_LAST);
    h_wrap = (h_cnt_q == H_LAST);
    v_wrap = (v_cnt_q == V_LAST);

    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;

    if (tick) begin
      // Raster and cell counters. The cell counters track the pixel under
      // h_cnt/v_cnt and freeze during blanking, so no divide is needed.
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
      if (h_wrap) begin
        sub_x_d = '0;
        col_d   = '0;
        v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
        if (v_wrap) begin
          sub_y_d = '0;
          row_d   = '0;
        end else if (v_cnt_q < V_ACT) begin
          sub_y_d = (sub_y_q == SUB_LAST) ? '0 : sub_y_q + 1'b1;
          row_d   = (sub_y_q == SUB_LAST) ? row_q + 1'b1 : row_q;
        end
      end else if (h_cnt_q < H_ACT) begin
        sub_x_d = (sub_x_q == SUB_LAST) ? '0 : sub_x_q + 1'b1;
        col_d   = (sub_x_q == SUB_LAST) ? col_q + 1'b1 : col_q;
      end

      s1_de_d      = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      s1_hs_d      = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
      s1_vs_d      = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
      s1_first_d   = (h_cnt_q == '0) && (v_cnt_q == '0);
      s1_in_grid_d = (32'(row_q) < GRID_ROWS) && (32'(col_q) < GRID_COLS);
      s1_idx_d     = IDX_W'(32'(row_q) * GRID_COLS + 32'(col_q));
`ifdef GRID_LINES_EN
      s1_line_d    = (sub_x_q == '0) || (sub_y_q == '0);
`endif

      de_d = s1_de_q;
      hs_d = s1_hs_q;
      vs_d = s1_vs_q;
      fs_d = s1_first_q && s1_de_q;
      if (!s1_de_q) begin
        rgb_d = 24'h000000;
      end else if (s1_in_grid_q && shadow_q[s1_idx_q]) begin
        rgb_d = FG_RGB;
`ifdef GRID_LINES_EN
      end else if (s1_in_grid_q && s1_line_q) begin
        rgb_d = LINE_RGB;
`endif
      end else begin
        rgb_d = BG_RGB;
      end

      // Snapshot on the first blanking line: the whole next frame reads a
      // stable bitmap, so it never tears.
      if ((h_cnt_q == '0) && (v_cnt_q == V_ACT)) begin
        shadow_d = grid_in;
      end
    end
  end

  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      div_cnt_q    <= '0;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      sub_x_q      <= '0;
      sub_y_q      <= '0;
      col_q        <= '0;
      row_q        <= '0;
      shadow_q     <= '0;
      s1_idx_q     <= '0;
      s1_in_grid_q <= 1'b0;
      s1_de_q      <= 1'b0;
      s1_hs_q      <= 1'b0;
      s1_vs_q      <= 1'b0;
      s1_first_q   <= 1'b0;
`ifdef GRID_LINES_EN
      s1_line_q    <= 1'b0;
`endif
      rgb_q        <= '0;
      de_q         <= 1'b0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      fs_q         <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      sub_x_q      <= sub_x_d;
      sub_y_q      <= sub_y_d;
      col_q        <= col_d;
      row_q        <= row_d;
      shadow_q     <= shadow_d;
      s1_idx_q     <= s1_idx_d;
      s1_in_grid_q <= s1_in_grid_d;
      s1_de_q      <= s1_de_d;
      s1_hs_q      <= s1_hs_d;
      s1_vs_q      <= s1_vs_d;
      s1_first_q   <= s1_first_d;
`ifdef GRID_LINES_EN
      s1_line_q    <= s1_line_d;
`endif
      rgb_q        <= rgb_d;
      de_q         <= de_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      fs_q         <= fs_d;
    end
  end

  // Gated with reset_n so that the strobe stays low during reset even when
  // PIX_DIV is 1.
  assign pix_en      = tick & reset_n;
  assign video_hs    = hs_q;
  assign video_vs    = vs_q;
  assign video_de    = de_q;
  assign video_rgb   = rgb_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_grid_video_renderer.sv
// Bench for grid_video_renderer. It uses a reduced raster and grid with a
// non-power-of-two cell size and pixel divider, so that several whole
// frames fit into a short run.
module tb_grid_video_renderer;

  localparam int GR = 6, GC = 8, CP = 3, PD = 3;
  localparam int HA = 28, HF = 4, HS = 6, HB = 4;
  localparam int VA = 20, VF = 2, VS = 3, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int NB = GR * GC;
  localparam int FRAME_CLK = HT * VT * PD;
  localparam logic [23:0] FG = 24'h00FF00;
  localparam logic [23:0] BG = 24'h0000A0;
`ifdef GRID_LINES_EN
  localparam logic [23:0] LN = 24'h202020;
`endif
  localparam int W = 28;  // {frame_start, de, hs, vs, rgb[23:0]}

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NB-1:0] grid_in = '0;
  logic          pix_en, video_hs, video_vs, video_de, frame_start;
  logic [23:0]   video_rgb;

  always #5 clk = ~clk;

  grid_video_renderer #(
    .GRID_ROWS(GR), .GRID_COLS(GC), .CELL_PX(CP), .PIX_DIV(PD),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .FG_RGB(FG), .BG_RGB(BG)
`ifdef GRID_LINES_EN
    , .LINE_RGB(LN)
`endif
  ) dut (
    .clk_74a(clk),
    .reset_n(reset_n),
    .grid_in(grid_in),
    .pix_en(pix_en),
    .video_hs(video_hs),
    .video_vs(video_vs),
    .video_de(video_de),
    .video_rgb(video_rgb),
    .frame_start(frame_start)
  );

  int checks = 0;
  int fails  = 0;
  logic [W-1:0] exp_q[$];

  // rst_q: reset was applied at the last edge. tick_seen: the last edge was a pixel tick.
  logic rst_q = 1'b1;
  logic tick_seen = 1'b0;
  always @(posedge clk) begin
    rst_q     <= !reset_n;
    tick_seen <= pix_en;
  end

  // Reference: expected output for raster position (x,y) given the frame's bitmap.
  function automatic logic [W-1:0] ref_pixel(int x, int y, logic [NB-1:0] shadow);
    logic de, hs, vs, fs, ing, lit;
    logic [23:0] rgb;
    int cx, cy;
    de  = (x < HA) && (y < VA);
    hs  = (x >= HA + HF) && (x < HA + HF + HS);
    vs  = (y >= VA + VF) && (y < VA + VF + VS);
    fs  = (x == 0) && (y == 0);
    cx  = x / CP;
    cy  = y / CP;
    ing = (cx < GC) && (cy < GR);
    lit = 1'b0;
    if (ing) lit = shadow[cy * GC + cx];
    rgb = 24'h000000;
    if (de) begin
      if (lit) begin
        rgb = FG;
      end else begin
        rgb = BG;
`ifdef GRID_LINES_EN
        if (ing && ((x % CP == 0) || (y % CP == 0))) rgb = LN;
`endif
      end
    end
    return {fs, de, hs, vs, rgb};
  endfunction

  // Model: expected raster position, divider phase and latched bitmap.
  int mh = 0, mv = 0, mdiv = 0;
  logic [NB-1:0] mshadow = '0;
  logic exp_pe;

  always @(negedge clk) begin
    if (rst_q) begin
      mh = 0; mv = 0; mdiv = 0; mshadow = '0; exp_pe = 1'b0;
    end else begin
      mdiv   = (mdiv + 1) % PD;
      exp_pe = (mdiv == PD - 1);
    end
    checks++;
    if (pix_en !== exp_pe) begin
      fails++;
      $display("FAIL pix_en t=%0t got=%b expected=%b", $time, pix_en, exp_pe);
    end
    if (exp_pe) begin
      exp_q.push_back(ref_pixel(mh, mv, mshadow));
      if (mh == 0 && mv == VA) mshadow = grid_in;
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
  end

  // Monitor: a pixel reaches the outputs on each tick from the second one after reset.
  logic [W-1:0] last_exp = '0;
  logic [W-1:0] got, want;
  int dticks = 0;

  always @(negedge clk) begin
    if (rst_q) begin
      exp_q.delete();
      dticks   = 0;
      last_exp = '0;
    end else if (tick_seen) begin
      dticks++;
      if (dticks >= 2) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL queue_empty t=%0t got=no expected entry required=one entry", $time);
        end else begin
          last_exp = exp_q.pop_front();
        end
      end
    end
    want = last_exp;
    if (rst_q || !tick_seen) want[W-1] = 1'b0;
    got = {frame_start, video_de, video_hs, video_vs, video_rgb};
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL video_out t=%0t got fs=%b de=%b hs=%b vs=%b rgb=%h expected fs=%b de=%b hs=%b vs=%b rgb=%h",
               $time, got[W-1], got[W-2], got[W-3], got[W-4], got[23:0],
               want[W-1], want[W-2], want[W-3], want[W-4], want[23:0]);
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_line(input int line);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < FRAME_CLK + 100; i++) begin
      @(posedge clk);
      if (mv == line && !rst_q) begin
        hit = 1'b1;
        break;
      end
    end
    #1;
    checks++;
    if (!hit) begin
      fails++;
      $display("FAIL wait_line got=timeout required=line %0d", line);
    end
  endtask

  task automatic rand_grid();
    for (int i = 0; i < NB; i++) grid_in[i] = 1'($urandom_range(0, 1));
  endtask

  initial begin
    reset_n = 1'b0;
    grid_in = '0;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b1;

    // Only the origin cell lit.
    grid_in    = '0;
    grid_in[0] = 1'b1;
    wait_clks(2 * FRAME_CLK + 50);

    // Only the far-corner cell lit.
    grid_in       = '0;
    grid_in[NB-1] = 1'b1;
    wait_clks(2 * FRAME_CLK);

    // Bitmap changes during the active area.
    wait_line(VA / 2);
    rand_grid();
    wait_line(VA / 2 + 3);
    rand_grid();
    wait_clks(2 * FRAME_CLK);

    // Reset held for three clocks in the middle of a frame.
    wait_line(15);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    wait_clks(2 * FRAME_CLK);

    // Random bitmaps loaded at random lines.
    for (int k = 0; k < 2; k++) begin
      wait_line($urandom_range(0, VT - 1));
      rand_grid();
      wait_clks($urandom_range(0, FRAME_CLK));
    end
    wait_clks(FRAME_CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
